// File: rtl/snake_btn_conditioner.sv
// Button front end for the snake game: synchronises and debounces the five board
// buttons, then arbitrates them into single direction and ack requests for snake_core.
module snake_btn_conditioner #(
  parameter int N_DC = 20
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_c,
  input  logic       game_tick,
  input  logic [1:0] cur_dir,
  output logic [4:0] btn_level,
  output logic [4:0] press_pulse,
  output logic       dir_valid,
  output logic [1:0] dir_req,
  output logic       ack_req
);

  // state   | meaning
  // IDLE    | released and stable
  // CHK_P   | input high, timing the press window
  // PRESSED | pressed and stable
  // CHK_R   | input low, timing the release window
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHK_P   = 2'd1,
    PRESSED = 2'd2,
    CHK_R   = 2'd3
  } db_state_t;

  localparam logic [N_DC-1:0] CNT_TERM = '1;

  logic [4:0]      btn_raw;
  logic [4:0]      sync_1;
  logic [4:0]      sync_2;
  db_state_t       state     [5];
  db_state_t       state_nxt [5];
  logic [N_DC-1:0] cnt       [5];
  logic [N_DC-1:0] cnt_nxt   [5];
  logic [N_DC-1:0] cnt_inc   [5];
  logic [4:0]      pulse_nxt;
  logic [4:0]      level_nxt;

  assign btn_raw = {btn_u, btn_d, btn_l, btn_r, btn_c};

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
      press_pulse <= '0;
      btn_level   <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
      press_pulse <= pulse_nxt;
      btn_level   <= level_nxt;
    end
  end

  // Transitions fire on the edge where the saturating count reaches terminal.
  always_comb begin
    pulse_nxt = '0;
    level_nxt = '0;
    for (int i = 0; i < 5; i++) begin
      state_nxt[i] = state[i];
      cnt_inc[i]   = (cnt[i] == CNT_TERM) ? cnt[i] : cnt[i] + 1'b1;
      cnt_nxt[i]   = cnt[i];
      unique case (state[i])
        IDLE: begin
          if (sync_2[i]) begin
            state_nxt[i] = CHK_P;
            cnt_nxt[i]   = '0;
          end
        end
        CHK_P: begin
          cnt_nxt[i] = cnt_inc[i];
          if (!sync_2[i]) begin
            state_nxt[i] = IDLE;
          end else if (cnt_inc[i] == CNT_TERM) begin
            state_nxt[i] = PRESSED;
            pulse_nxt[i] = 1'b1;
          end
        end
        PRESSED: begin
          if (!sync_2[i]) begin
            state_nxt[i] = CHK_R;
            cnt_nxt[i]   = '0;
          end
        end
        CHK_R: begin
          cnt_nxt[i] = cnt_inc[i];
          if (sync_2[i]) begin
            state_nxt[i] = PRESSED;
          end else if (cnt_inc[i] == CNT_TERM) begin
            state_nxt[i] = IDLE;
          end
        end
        default: state_nxt[i] = IDLE;
      endcase
      level_nxt[i] = (state_nxt[i] == PRESSED) || (state_nxt[i] == CHK_R);
    end
  end

  logic       dir_hit;
  logic [1:0] dir_cand;
  logic       dir_opposite;
  logic       dir_accept;

  always_comb begin
    dir_hit  = |press_pulse[4:1];
    dir_cand = 2'b00;
    if (press_pulse[4])      dir_cand = 2'b00;
    else if (press_pulse[3]) dir_cand = 2'b01;
    else if (press_pulse[2]) dir_cand = 2'b10;
    else if (press_pulse[1]) dir_cand = 2'b11;
    dir_opposite = (dir_cand[1] == cur_dir[1]) && (dir_cand[0] != cur_dir[0]);
    dir_accept   = dir_hit && !dir_opposite;
  end

  // A fresh press beats a coincident game_tick so the request survives to the next tick.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      dir_valid <= 1'b0;
      dir_req   <= 2'b00;
      ack_req   <= 1'b0;
    end else begin
      if (dir_accept) begin
        dir_valid <= 1'b1;
        dir_req   <= dir_cand;
      end else if (game_tick) begin
        dir_valid <= 1'b0;
      end
      if (press_pulse[0])  ack_req <= 1'b1;
      else if (game_tick)  ack_req <= 1'b0;
    end
  end

endmodule

// File: tb/tb_snake_btn_conditioner.sv
// Directed bench for snake_btn_conditioner with N_DC=4 (press latency 18 cycles).
module tb_snake_btn_conditioner;

  logic       board_clk = 1'b0;
  logic       reset     = 1'b1;
  logic [4:0] btn       = '0;
  logic       game_tick = 1'b0;
  logic [1:0] cur_dir   = 2'b00;
  logic [4:0] btn_level;
  logic [4:0] press_pulse;
  logic       dir_valid;
  logic [1:0] dir_req;
  logic       ack_req;

  int errors = 0;
  int checks = 0;
  int pulse_cnt [5];

  snake_btn_conditioner #(.N_DC(4)) dut (
    .board_clk  (board_clk),
    .reset      (reset),
    .btn_u      (btn[4]),
    .btn_d      (btn[3]),
    .btn_l      (btn[2]),
    .btn_r      (btn[1]),
    .btn_c      (btn[0]),
    .game_tick  (game_tick),
    .cur_dir    (cur_dir),
    .btn_level  (btn_level),
    .press_pulse(press_pulse),
    .dir_valid  (dir_valid),
    .dir_req    (dir_req),
    .ack_req    (ack_req)
  );

  always #5 board_clk = ~board_clk;

  initial for (int i = 0; i < 5; i++) pulse_cnt[i] = 0;

  always @(negedge board_clk) begin
    for (int i = 0; i < 5; i++) if (press_pulse[i]) pulse_cnt[i] = pulse_cnt[i] + 1;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge board_clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    btn       = '0;
    game_tick = 1'b0;
    reset     = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  task automatic press_btn(input int idx);
    btn[idx] = 1'b1;
    step(20);
    btn[idx] = 1'b0;
    step(20);
  endtask

  task automatic pulse_tick();
    game_tick = 1'b1;
    step(1);
    game_tick = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({btn_level, press_pulse, dir_valid, dir_req, ack_req} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {btn_level, press_pulse, dir_valid, dir_req, ack_req});
    end
  endtask

  task automatic test_press_latency();
    apply_reset();
    cur_dir = 2'b00;
    btn[4] = 1'b1;
    step(17);
    checks++;
    if (press_pulse[4] !== 1'b0) begin
      errors++; $display("FAIL latency_early: pulse=%b expected 0 at T+17", press_pulse[4]);
    end
    step(1);
    checks++;
    if (press_pulse !== 5'b10000) begin
      errors++; $display("FAIL latency_pulse: pulse=%b expected 10000 at T+18", press_pulse);
    end
    checks++;
    if (dir_valid !== 1'b0) begin
      errors++; $display("FAIL latency_dir_early: dir_valid=%b expected 0 at T+18", dir_valid);
    end
    step(1);
    checks++;
    if (press_pulse[4] !== 1'b0) begin
      errors++; $display("FAIL latency_single: pulse=%b expected 0 at T+19", press_pulse[4]);
    end
    checks++;
    if (dir_valid !== 1'b1 || dir_req !== 2'b00) begin
      errors++; $display("FAIL latency_dir: valid=%b req=%b expected 1/00", dir_valid, dir_req);
    end
    step(5);
    btn[4] = 1'b0;
    step(17);
    checks++;
    if (btn_level[4] !== 1'b1) begin
      errors++; $display("FAIL release_hold: level=%b expected 1 at R+17", btn_level[4]);
    end
    step(1);
    checks++;
    if (btn_level[4] !== 1'b0) begin
      errors++; $display("FAIL release_fall: level=%b expected 0 at R+18", btn_level[4]);
    end
  endtask

  task automatic test_bounce();
    int base;
    apply_reset();
    base = pulse_cnt[2];
    for (int i = 0; i < 12; i++) begin
      btn[2] = ~btn[2];
      step(5);
    end
    checks++;
    if (pulse_cnt[2] !== base) begin
      errors++; $display("FAIL bounce_quiet: pulses=%0d expected %0d", pulse_cnt[2], base);
    end
    btn[2] = 1'b1;
    step(17);
    checks++;
    if (press_pulse[2] !== 1'b0) begin
      errors++; $display("FAIL bounce_early: pulse=%b expected 0 at L+17", press_pulse[2]);
    end
    step(1);
    checks++;
    if (press_pulse[2] !== 1'b1) begin
      errors++; $display("FAIL bounce_pulse: pulse=%b expected 1 at L+18", press_pulse[2]);
    end
    step(10);
    checks++;
    if (pulse_cnt[2] !== base + 1) begin
      errors++; $display("FAIL bounce_count: pulses=%0d expected %0d", pulse_cnt[2], base + 1);
    end
    btn[2] = 1'b0;
    step(20);
  endtask

  task automatic test_reversal();
    apply_reset();
    cur_dir = 2'b00;
    press_btn(3);
    checks++;
    if (dir_valid !== 1'b0) begin
      errors++; $display("FAIL reversal_reject: dir_valid=%b expected 0", dir_valid);
    end
    press_btn(1);
    checks++;
    if (dir_valid !== 1'b1 || dir_req !== 2'b11) begin
      errors++; $display("FAIL reversal_accept: valid=%b req=%b expected 1/11", dir_valid, dir_req);
    end
    pulse_tick();
    checks++;
    if (dir_valid !== 1'b0) begin
      errors++; $display("FAIL tick_consume: dir_valid=%b expected 0", dir_valid);
    end
  endtask

  task automatic test_priority();
    apply_reset();
    cur_dir = 2'b10;
    btn[4] = 1'b1;
    btn[2] = 1'b1;
    step(18);
    checks++;
    if (press_pulse !== 5'b10100) begin
      errors++; $display("FAIL prio_pulses: pulse=%b expected 10100", press_pulse);
    end
    step(1);
    checks++;
    if (dir_valid !== 1'b1 || dir_req !== 2'b00) begin
      errors++; $display("FAIL prio_u_wins: valid=%b req=%b expected 1/00", dir_valid, dir_req);
    end
    btn = '0;
    step(20);
    press_btn(2);
    checks++;
    if (dir_req !== 2'b10) begin
      errors++; $display("FAIL last_wins_l: req=%b expected 10", dir_req);
    end
    press_btn(4);
    checks++;
    if (dir_valid !== 1'b1 || dir_req !== 2'b00) begin
      errors++; $display("FAIL last_wins_u: valid=%b req=%b expected 1/00", dir_valid, dir_req);
    end
  endtask

  task automatic test_ack_collision();
    apply_reset();
    press_btn(0);
    checks++;
    if (ack_req !== 1'b1) begin
      errors++; $display("FAIL ack_set: ack_req=%b expected 1", ack_req);
    end
    btn[0] = 1'b1;
    step(18);
    checks++;
    if (press_pulse[0] !== 1'b1) begin
      errors++; $display("FAIL ack_pulse_align: pulse=%b expected 1", press_pulse[0]);
    end
    pulse_tick();
    checks++;
    if (ack_req !== 1'b1) begin
      errors++; $display("FAIL ack_press_wins: ack_req=%b expected 1", ack_req);
    end
    btn[0] = 1'b0;
    step(20);
    pulse_tick();
    checks++;
    if (ack_req !== 1'b0) begin
      errors++; $display("FAIL ack_consume: ack_req=%b expected 0", ack_req);
    end
  endtask

  task automatic test_reset_midrequest();
    apply_reset();
    cur_dir = 2'b00;
    btn[1] = 1'b1;
    step(20);
    checks++;
    if (dir_valid !== 1'b1 || btn_level[1] !== 1'b1) begin
      errors++; $display("FAIL mid_setup: valid=%b level=%b expected 1/1", dir_valid, btn_level[1]);
    end
    reset = 1'b1;
    step(1);
    checks++;
    if ({btn_level, press_pulse, dir_valid, dir_req, ack_req} !== 14'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b expected all zero",
               {btn_level, press_pulse, dir_valid, dir_req, ack_req});
    end
    step(2);
    reset = 1'b0;
    step(17);
    checks++;
    if (press_pulse[1] !== 1'b0 || btn_level[1] !== 1'b0) begin
      errors++; $display("FAIL mid_no_early: pulse=%b level=%b expected 0/0", press_pulse[1], btn_level[1]);
    end
    step(1);
    checks++;
    if (press_pulse[1] !== 1'b1) begin
      errors++; $display("FAIL mid_repulse: pulse=%b expected 1 at D+18", press_pulse[1]);
    end
    btn[1] = 1'b0;
    step(20);
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_bounce();
    test_reversal();
    test_priority();
    test_ack_collision();
    test_reset_midrequest();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
